// File: rtl/cpu_ctrl_pkg.sv
// Shared types and helpers for the CPU control blocks.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_T0     = 3'd1,
    S_T1     = 3'd2,
    S_T2     = 3'd3,
    S_EXEC   = 3'd4,
    S_BRANCH = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } fetch_state_t;

  // Control strobes driven onto the datapath, one bit per port.
  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic pc_in;
    logic exec_start;
    logic halted;
    logic fault;
  } fetch_strobes_t;

  localparam int unsigned DEFAULT_MEM_TIMEOUT = 8;
  localparam int unsigned WAIT_WIDTH = $clog2(DEFAULT_MEM_TIMEOUT + 1);

  // Wait-counter width for an arbitrary timeout value.
  function automatic int unsigned wait_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

  // Moore decode of a state into its strobes; first_exec marks the EXEC entry cycle.
  function automatic fetch_strobes_t decode_strobes(input fetch_state_t s,
                                                    input logic first_exec);
    fetch_strobes_t o;
    o = '0;
    case (s)
      S_T0: begin
        o.pc_out = 1'b1;
        o.mar_in = 1'b1;
        o.inc_pc = 1'b1;
      end
      S_T1: begin
        o.read   = 1'b1;
        o.mdr_in = 1'b1;
      end
      S_T2: begin
        o.mdr_out = 1'b1;
        o.ir_in   = 1'b1;
      end
      S_EXEC:   o.exec_start = first_exec;
      S_BRANCH: o.pc_in      = 1'b1;
      S_HALT:   o.halted     = 1'b1;
      S_FAULT:  o.fault      = 1'b1;
      default:  o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts T1 wait cycles; expired is high in the cycle the count reaches LIMIT-1.
module mem_wait_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_MEM_TIMEOUT,
  parameter int unsigned WIDTH = WAIT_WIDTH
) (
  input  logic clock,
  input  logic clear,
  input  logic start,
  input  logic count,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] cnt;

  // Counter and registered expiry flag; start reloads zero, count advances up to LAST.
  always_ff @(posedge clock) begin
    if (clear || start) begin
      cnt     <= '0;
      expired <= (LAST == '0);
    end else if (count) begin
      if (cnt != LAST) begin
        cnt     <= cnt + WIDTH'(1);
        expired <= ((cnt + WIDTH'(1)) == LAST);
      end else begin
        expired <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_control_unit.sv
// Instruction-fetch sequencer: T0-T2 fetch, execute handoff, branch load, halt and timeout.
module fetch_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 run,
  input  logic                 stall,
  input  logic                 mem_ready,
  input  logic                 exec_done,
  input  logic                 branch_taken,
  input  logic                 halt_req,
  output logic                 PCout,
  output logic                 MARin,
  output logic                 IncPC,
  output logic                 Read,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 PCin,
  output logic                 exec_start,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  localparam int unsigned WW = wait_width(MEM_TIMEOUT);

  fetch_state_t   state;
  fetch_state_t   state_next;
  fetch_strobes_t strobes_q;
  fetch_strobes_t strobes_next;
  logic           halt_pending;
  logic           wait_expired;
  logic           resume_fetch;
  fetch_state_t   after_instr;

  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT),
    .WIDTH (WW)
  ) u_mem_wait_timer (
    .clock   (clock),
    .clear   (clear),
    .start   (state == S_T0),
    .count   (state == S_T1),
    .expired (wait_expired)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (clear) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic and the strobe decode of the next state.
  always_comb begin
    state_next   = state;
    resume_fetch = run && !stall;
    after_instr  = halt_pending ? S_HALT : (resume_fetch ? S_T0 : S_IDLE);
    case (state)
      S_IDLE:   state_next = after_instr;
      S_T0:     state_next = S_T1;
      S_T1: begin
        if (mem_ready)         state_next = S_T2;
        else if (wait_expired) state_next = S_FAULT;
      end
      S_T2:     state_next = S_EXEC;
      S_EXEC: begin
        if (exec_done) state_next = branch_taken ? S_BRANCH : after_instr;
      end
      S_BRANCH: state_next = after_instr;
      S_HALT:   state_next = S_HALT;
      S_FAULT:  state_next = S_FAULT;
      default:  state_next = S_IDLE;
    endcase
    strobes_next = decode_strobes(state_next, (state_next == S_EXEC) && (state != S_EXEC));
  end

  // Registered strobes, sticky halt request and saturating retired-fetch counter.
  always_ff @(posedge clock) begin
    if (clear) begin
      strobes_q    <= '0;
      halt_pending <= 1'b0;
      fetch_count  <= '0;
    end else begin
      strobes_q <= strobes_next;
      if (halt_req && (state != S_HALT) && (state != S_FAULT)) halt_pending <= 1'b1;
      if ((state == S_T2) && (fetch_count != '1)) fetch_count <= fetch_count + CNT_WIDTH'(1);
    end
  end

  assign PCout      = strobes_q.pc_out;
  assign MARin      = strobes_q.mar_in;
  assign IncPC      = strobes_q.inc_pc;
  assign Read       = strobes_q.read;
  assign MDRin      = strobes_q.mdr_in;
  assign MDRout     = strobes_q.mdr_out;
  assign IRin       = strobes_q.ir_in;
  assign PCin       = strobes_q.pc_in;
  assign exec_start = strobes_q.exec_start;
  assign halted     = strobes_q.halted;
  assign fault      = strobes_q.fault;

endmodule

// File: tb/tb_fetch_control_unit.sv
// Scoreboard bench for fetch_control_unit against a cycle-count reference model.
module tb_fetch_control_unit;

  localparam int MEM_TIMEOUT = 8;

  // Model phases (instruction life cycle, not the RTL encoding).
  localparam int PH_IDLE  = 0;
  localparam int PH_ADDR  = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_LOAD  = 3;
  localparam int PH_EXEC  = 4;
  localparam int PH_BR    = 5;
  localparam int PH_HALT  = 6;
  localparam int PH_FAULT = 7;

  typedef struct {
    int         tag;
    logic [10:0] outs;
    int         cnt_wide;
    int         cnt_sat;
  } exp_t;

  logic clock, clear, run, stall, mem_ready, exec_done, branch_taken, halt_req;

  logic PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, PCin, exec_start, halted, fault;
  logic [15:0] fetch_count;
  logic s_PCout, s_MARin, s_IncPC, s_Read, s_MDRin, s_MDRout, s_IRin, s_PCin;
  logic s_exec_start, s_halted, s_fault;
  logic [1:0] s_fetch_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t sb[$];

  // Reference model state.
  int m_phase = PH_IDLE;
  int m_t1 = 0;
  bit m_first = 0;
  bit m_pend = 0;
  int m_count = 0;

  fetch_control_unit #(.CNT_WIDTH(16), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock(clock), .clear(clear), .run(run), .stall(stall), .mem_ready(mem_ready),
    .exec_done(exec_done), .branch_taken(branch_taken), .halt_req(halt_req),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .PCin(PCin), .exec_start(exec_start),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  fetch_control_unit #(.CNT_WIDTH(2), .MEM_TIMEOUT(MEM_TIMEOUT)) dut_sat (
    .clock(clock), .clear(clear), .run(run), .stall(stall), .mem_ready(mem_ready),
    .exec_done(exec_done), .branch_taken(branch_taken), .halt_req(halt_req),
    .PCout(s_PCout), .MARin(s_MARin), .IncPC(s_IncPC), .Read(s_Read), .MDRin(s_MDRin),
    .MDRout(s_MDRout), .IRin(s_IRin), .PCin(s_PCin), .exec_start(s_exec_start),
    .halted(s_halted), .fault(s_fault), .fetch_count(s_fetch_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Strobes the datapath should see while the instruction is in a given phase.
  function automatic logic [10:0] phase_outs(input int ph, input bit first);
    logic [10:0] o;
    o = 11'd0;
    if (ph == PH_ADDR)  o = 11'b111_00_00_0_0_0_0;
    if (ph == PH_WAIT)  o = 11'b000_11_00_0_0_0_0;
    if (ph == PH_LOAD)  o = 11'b000_00_11_0_0_0_0;
    if (ph == PH_EXEC)  o = {9'd0, first, 1'b0} << 1;
    if (ph == PH_BR)    o = 11'b000_00_00_1_0_0_0;
    if (ph == PH_HALT)  o = 11'b000_00_00_0_0_1_0;
    if (ph == PH_FAULT) o = 11'b000_00_00_0_0_0_1;
    return o;
  endfunction

  // Drive one cycle of inputs, advance the model across the coming edge, queue the expectation.
  task automatic step(input bit clr, input bit r, input bit st, input bit mr,
                      input bit ed, input bit bt, input bit hr);
    exp_t e;
    int np;
    int resume;
    @(posedge clock);
    #1;
    clear = clr; run = r; stall = st; mem_ready = mr;
    exec_done = ed; branch_taken = bt; halt_req = hr;
    if (clr) begin
      m_phase = PH_IDLE; m_t1 = 0; m_first = 0; m_pend = 0; m_count = 0;
    end else begin
      resume = m_pend ? PH_HALT : ((r && !st) ? PH_ADDR : PH_IDLE);
      np = m_phase;
      case (m_phase)
        PH_IDLE: np = resume;
        PH_ADDR: begin np = PH_WAIT; m_t1 = 0; end
        PH_WAIT: begin
          m_t1 = m_t1 + 1;
          if (mr) np = PH_LOAD;
          else if (m_t1 >= MEM_TIMEOUT) np = PH_FAULT;
        end
        PH_LOAD: begin np = PH_EXEC; m_count = m_count + 1; end
        PH_EXEC: if (ed) np = bt ? PH_BR : resume;
        PH_BR:   np = resume;
        default: np = m_phase;
      endcase
      if (hr && m_phase != PH_HALT && m_phase != PH_FAULT) m_pend = 1;
      m_first = (np == PH_EXEC) && (m_phase != PH_EXEC);
      m_phase = np;
    end
    e.tag = cyc + 1;
    e.outs = phase_outs(m_phase, m_first);
    e.cnt_wide = (m_count > 65535) ? 65535 : m_count;
    e.cnt_sat = (m_count > 3) ? 3 : m_count;
    sb.push_back(e);
  endtask

  // Monitor: compare the DUT against each expectation in the cycle it applies to.
  initial begin
    exp_t e;
    logic [10:0] got, got_s;
    forever begin
      @(negedge clock);
      got   = {PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, PCin, exec_start, halted, fault};
      got_s = {s_PCout, s_MARin, s_IncPC, s_Read, s_MDRin, s_MDRout, s_IRin, s_PCin,
               s_exec_start, s_halted, s_fault};
      while (sb.size() > 0 && sb[0].tag <= cyc) begin
        e = sb.pop_front();
        checks = checks + 1;
        if (e.tag != cyc) begin
          failures = failures + 1;
          $display("FAIL stale_entry tag=%0d cycle=%0d", e.tag, cyc);
        end
        checks = checks + 1;
        if (got !== e.outs) begin
          failures = failures + 1;
          $display("FAIL strobes cycle=%0d got=%b want=%b", cyc, got, e.outs);
        end
        checks = checks + 1;
        if (fetch_count !== 16'(e.cnt_wide)) begin
          failures = failures + 1;
          $display("FAIL fetch_count cycle=%0d got=%0d want=%0d", cyc, fetch_count, e.cnt_wide);
        end
        checks = checks + 1;
        if (got_s !== e.outs || s_fetch_count !== 2'(e.cnt_sat)) begin
          failures = failures + 1;
          $display("FAIL sat_dut cycle=%0d got=%b/%0d want=%b/%0d", cyc, got_s, s_fetch_count,
                   e.outs, e.cnt_sat);
        end
        checks = checks + 1;
        if (IncPC === 1'b1 && PCin === 1'b1) begin
          failures = failures + 1;
          $display("FAIL incpc_pcin_overlap cycle=%0d got=1 want=0", cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int delay;
    int rdy_pct;
    clear = 1'b1; run = 0; stall = 0; mem_ready = 0;
    exec_done = 0; branch_taken = 0; halt_req = 0;

    // Reset, then back-to-back single-cycle instructions.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 1, 1, 0, 0);

    // Memory waits of 3 cycles, then a never-ready fetch into FAULT and hold.
    step(1, 0, 0, 0, 0, 0, 0);
    delay = 3;
    for (int i = 0; i < 20; i++)
      step(0, 1, 0, !(m_phase == PH_WAIT && m_t1 < delay), 1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 1, 0, 0);

    // Taken branches, with stall and mem_ready noise outside T1.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, (i == 1), 1, 1, 1, 0);

    // Halt requested during T1; run afterwards is ignored.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 1, 0, 1, 1, 0, (m_phase == PH_WAIT));

    // Halt requested in IDLE.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 1, 0, 0);

    // Clear in T1 and in EXEC.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(m_phase == PH_WAIT && i > 5, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(m_phase == PH_EXEC && i > 5, 1, 0, 1, 0, 0, 0);

    // Randomized traffic.
    for (int seg = 0; seg < 8; seg++) begin
      rdy_pct = $urandom_range(20, 100);
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 2) == 0,
             1'($urandom_range(0, 1)), $urandom_range(0, 79) == 0);
    end

    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    checks = checks + 1;
    if (sb.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
